// File: rtl/cache_types_pkg.sv
// cache_types_pkg: shared line/burst geometry and adaptor state encoding
// Rev 1.0
`default_nettype none

package cache_types_pkg;

  localparam int s_offset = 5;
  localparam int s_line   = 8 * (2 ** s_offset);
  localparam int s_burst  = 64;
  localparam int n_beats  = s_line / s_burst;
  localparam int cnt_w    = $clog2(n_beats);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    RD_BURST = 2'd1,
    WR_BURST = 2'd2,
    DONE     = 2'd3
  } adaptor_state_t;

  typedef logic [s_line-1:0]  line_t;
  typedef logic [s_burst-1:0] burst_t;

endpackage

`default_nettype wire

// File: rtl/beat_counter.sv
// beat_counter: modulo-N beat index with clear/enable and a last-beat flag
// Rev 1.0
`default_nettype none

module beat_counter #(
  parameter int N = 4,
  parameter int W = $clog2(N)
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr,
  input  logic         en,
  output logic [W-1:0] count,
  output logic         last_beat
);

  assign last_beat = (count == W'(N - 1));

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      count <= '0;
    end else if (en) begin
      count <= last_beat ? '0 : count + 1'b1;
    end
  end

endmodule

`default_nettype wire

// File: rtl/cacheline_adaptor.sv
// cacheline_adaptor: turns single-line cache reads/writes into N-beat memory bursts
// Rev 1.0
`default_nettype none

module cacheline_adaptor
  import cache_types_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  line_t       line_i,
  output line_t       line_o,
  input  logic [31:0] address_i,
  input  logic        read_i,
  input  logic        write_i,
  output logic        resp_o,
  input  burst_t      burst_i,
  output burst_t      burst_o,
  output logic [31:0] address_o,
  output logic        read_o,
  output logic        write_o,
  input  logic        resp_i
);

  localparam logic [31:0] ADDR_MASK = 32'((1 << s_offset) - 1);

  adaptor_state_t   state;
  line_t            wr_line;
  logic [cnt_w-1:0] count;
  logic             last_beat;
  logic             cnt_clr;
  logic             cnt_en;

  assign cnt_clr = (state == IDLE);
  assign cnt_en  = resp_i && ((state == RD_BURST) || (state == WR_BURST));

  beat_counter #(
    .N (n_beats),
    .W (cnt_w)
  ) u_beat_counter (
    .clk       (clk),
    .rst       (rst),
    .clr       (cnt_clr),
    .en        (cnt_en),
    .count     (count),
    .last_beat (last_beat)
  );

  assign burst_o = write_o ? wr_line[count*s_burst +: s_burst] : '0;

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      wr_line   <= '0;
      line_o    <= '0;
      address_o <= '0;
      read_o    <= 1'b0;
      write_o   <= 1'b0;
      resp_o    <= 1'b0;
    end else begin
      resp_o <= 1'b0;
      case (state)
        IDLE: begin
          // The cache still holds its request during the resp_o cycle; don't re-issue it.
          if (!resp_o) begin
            if (read_i) begin
              address_o <= address_i & ~ADDR_MASK;
              read_o    <= 1'b1;
              state     <= RD_BURST;
            end else if (write_i) begin
              address_o <= address_i & ~ADDR_MASK;
              wr_line   <= line_i;
              write_o   <= 1'b1;
              state     <= WR_BURST;
            end
          end
        end
        RD_BURST: begin
          if (resp_i) begin
            line_o[count*s_burst +: s_burst] <= burst_i;
            if (last_beat) begin
              read_o <= 1'b0;
              state  <= DONE;
            end
          end
        end
        WR_BURST: begin
          if (resp_i && last_beat) begin
            write_o <= 1'b0;
            state   <= DONE;
          end
        end
        DONE: begin
          resp_o <= 1'b1;
          state  <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_cacheline_adaptor.sv
// tb_cacheline_adaptor: directed scoreboard bench for cacheline_adaptor
// Rev 1.0
`default_nettype none

module tb_cacheline_adaptor;
  import cache_types_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  line_t       line_i;
  line_t       line_o;
  logic [31:0] address_i;
  logic        read_i;
  logic        write_i;
  logic        resp_o;
  burst_t      burst_i;
  burst_t      burst_o;
  logic [31:0] address_o;
  logic        read_o;
  logic        write_o;
  logic        resp_i;

  int total = 0;
  int bad   = 0;

  line_t  exp_lines[$];
  burst_t exp_beats[$];

  cacheline_adaptor dut (
    .clk       (clk),
    .rst       (rst),
    .line_i    (line_i),
    .line_o    (line_o),
    .address_i (address_i),
    .read_i    (read_i),
    .write_i   (write_i),
    .resp_o    (resp_o),
    .burst_i   (burst_i),
    .burst_o   (burst_o),
    .address_o (address_o),
    .read_o    (read_o),
    .write_o   (write_o),
    .resp_i    (resp_i)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // strobes: bit k drives resp_i in the k-th beat cycle (pattern repeats every 8)
  task automatic do_read(input logic [31:0] addr, input line_t line, input logic [7:0] strobes,
                         input bit stray_done, input bit also_write);
    int   b;
    int   cyc;
    line_t exp;
    b   = 0;
    cyc = 0;
    address_i = addr;
    read_i    = 1'b1;
    write_i   = also_write;
    line_i    = ~line;
    exp_lines.push_back(line);
    tick();
    chk("rd_read_o_start", read_o, 1'b1);
    chk("rd_write_o_start", write_o, 1'b0);
    chk("rd_address_o", address_o, {addr[31:5], 5'b0});
    while (b < 4 && cyc < 32) begin
      resp_i  = strobes[cyc % 8];
      burst_i = resp_i ? line[b*64 +: 64] : 64'hDEAD_BEEF_0BAD_F00D;
      tick();
      if (resp_i) b++;
      chk("rd_read_o_burst", read_o, (b < 4));
      chk("rd_write_o_burst", write_o, 1'b0);
      cyc++;
    end
    if (b < 4) chk("rd_beat_timeout", 256'(b), 256'd4);
    resp_i  = stray_done;
    burst_i = 64'hBAD0_BAD0_BAD0_BAD0;
    chk("rd_resp_early", resp_o, 1'b0);
    tick();
    resp_i = 1'b0;
    chk("rd_resp_pulse", resp_o, 1'b1);
    chk("rd_write_o_done", write_o, 1'b0);
    if (exp_lines.size() > 0) begin
      exp = exp_lines.pop_front();
      chk("rd_line_o", line_o, exp);
    end
    tick();
    read_i  = 1'b0;
    write_i = 1'b0;
    chk("rd_resp_single", resp_o, 1'b0);
    chk("rd_no_reissue", read_o, 1'b0);
    chk("rd_line_held", line_o, line);
    tick();
    chk("rd_idle_read_o", read_o, 1'b0);
    chk("rd_idle_write_o", write_o, 1'b0);
  endtask

  task automatic do_write(input logic [31:0] addr, input line_t line, input logic [7:0] strobes);
    int cyc;
    cyc = 0;
    address_i = addr;
    write_i   = 1'b1;
    line_i    = line;
    tick();
    chk("wr_write_o_start", write_o, 1'b1);
    chk("wr_read_o_start", read_o, 1'b0);
    chk("wr_address_o", address_o, {addr[31:5], 5'b0});
    line_i = ~line;
    for (int k = 0; k < 4; k++) exp_beats.push_back(line[k*64 +: 64]);
    while (exp_beats.size() > 0 && cyc < 32) begin
      resp_i = strobes[cyc % 8];
      chk("wr_burst_o", burst_o, exp_beats[0]);
      tick();
      if (resp_i) void'(exp_beats.pop_front());
      chk("wr_write_o_burst", write_o, (exp_beats.size() > 0));
      chk("wr_read_o_burst", read_o, 1'b0);
      cyc++;
    end
    if (exp_beats.size() > 0) begin
      chk("wr_beat_timeout", 256'(exp_beats.size()), 256'd0);
      exp_beats.delete();
    end
    resp_i = 1'b0;
    chk("wr_resp_early", resp_o, 1'b0);
    tick();
    chk("wr_resp_pulse", resp_o, 1'b1);
    tick();
    write_i = 1'b0;
    chk("wr_resp_single", resp_o, 1'b0);
    chk("wr_no_duplicate", write_o, 1'b0);
    tick();
    chk("wr_idle_write_o", write_o, 1'b0);
    chk("wr_idle_resp_o", resp_o, 1'b0);
  endtask

  localparam line_t LINE_A = {64'h4444_4444_4444_4444, 64'h3333_3333_3333_3333,
                              64'h2222_2222_2222_2222, 64'h1111_1111_1111_1111};
  localparam line_t LINE_W = {64'hDDDD_0004_DDDD_0004, 64'hCCCC_0003_CCCC_0003,
                              64'hBBBB_0002_BBBB_0002, 64'hAAAA_0001_AAAA_0001};
  localparam line_t LINE_B = {64'h0123_4567_89AB_CDEF, 64'hFEDC_BA98_7654_3210,
                              64'h5555_AAAA_5555_AAAA, 64'h0F0F_F0F0_0F0F_F0F0};
  localparam line_t LINE_C = {64'h8000_0000_0000_0001, 64'h7FFF_FFFF_FFFF_FFFE,
                              64'hC0DE_C0DE_C0DE_C0DE, 64'h1234_5678_9ABC_DEF0};
  localparam line_t LINE_D = {64'hA5A5_A5A5_0000_0004, 64'h5A5A_5A5A_0000_0003,
                              64'hA5A5_A5A5_0000_0002, 64'h5A5A_5A5A_0000_0001};

  initial begin
    rst       = 1'b1;
    line_i    = '0;
    address_i = '0;
    read_i    = 1'b0;
    write_i   = 1'b0;
    burst_i   = '0;
    resp_i    = 1'b0;
    tick();
    tick();
    chk("rst_line_o", line_o, '0);
    chk("rst_address_o", address_o, '0);
    chk("rst_read_o", read_o, 1'b0);
    chk("rst_write_o", write_o, 1'b0);
    chk("rst_resp_o", resp_o, 1'b0);
    chk("rst_burst_o", burst_o, '0);
    rst = 1'b0;
    tick();

    // back-to-back read beats
    do_read(32'h0000_1234, LINE_A, 8'hFF, 1'b0, 1'b0);

    // stray strobes while idle
    resp_i  = 1'b1;
    burst_i = 64'hFFFF_FFFF_FFFF_FFFF;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("idle_stray_resp_o", resp_o, 1'b0);
      chk("idle_stray_line_o", line_o, LINE_A);
      chk("idle_stray_read_o", read_o, 1'b0);
    end
    resp_i = 1'b0;
    tick();

    // write with gaps 1,0,0,1,1,0,1 then a read two cycles later
    do_write(32'h0000_5678, LINE_W, 8'h59);
    tick();
    do_read(32'h0000_9A5F, LINE_B, 8'b0110_1101, 1'b1, 1'b0);

    // simultaneous read and write: read wins
    do_read(32'hFFFF_FFE7, LINE_C, 8'hFF, 1'b0, 1'b1);

    // reset after two read beats
    address_i = 32'h0000_0040;
    read_i    = 1'b1;
    tick();
    resp_i  = 1'b1;
    burst_i = 64'hEEEE_EEEE_EEEE_EEEE;
    tick();
    burst_i = 64'h9999_9999_9999_9999;
    tick();
    resp_i = 1'b0;
    read_i = 1'b0;
    rst    = 1'b1;
    exp_lines.delete();
    tick();
    rst = 1'b0;
    chk("mid_rst_line_o", line_o, '0);
    chk("mid_rst_address_o", address_o, '0);
    chk("mid_rst_read_o", read_o, 1'b0);
    chk("mid_rst_write_o", write_o, 1'b0);
    chk("mid_rst_resp_o", resp_o, 1'b0);
    chk("mid_rst_burst_o", burst_o, '0);
    tick();
    do_read(32'h0000_0040, LINE_D, 8'b1010_1011, 1'b0, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
